inst_fetch_unit: RTL and testbench

- Consumer of the program counter: takes the current `pc` each cycle and issues an instruction-memory read for it.
- Tracks in-flight reads in an in-order buffer and delivers {pc, inst} pairs to decode over a valid/ready handshake.
- Drives `pc_stall` back to the PC stage so the PC holds whenever a fetch cannot be launched.
- Discards wrong-path instructions on `flush`.

---
 rtl/inst_fetch_unit.sv | 131 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: issues imem reads for pc, buffers in-order responses and delivers {pc, inst} to decode.
// Optional FETCH_PERF_EN enables the stall/drop performance counters.
`ifndef WIDTH_PC
`define WIDTH_PC 32
`endif
module inst_fetch_unit #(
  parameter int PC_W   = `WIDTH_PC,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req_valid,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PC_W-1:0] SENT = {{(PC_W-2){1'b1}}, 2'b00};
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_d [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [AW:0] count_q, count_d, pend_q, pend_d, discard_q, discard_d;
  logic live, accept, pop, drop, fill_now;
  assign live = pc != SENT;
  assign imem_req_valid = !rst && !flush && live && (count_q + discard_q) < (AW+1)'(DEPTH);
  assign imem_req_addr = pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign pc_stall = live && !flush && !accept;
  assign out_valid = count_q != '0 && filled_q[head_q] && !flush;
  assign out_pc = pc_mem_q[head_q];
  assign out_inst = inst_mem_q[head_q];
  assign pop = out_valid && out_ready;
  assign drop = imem_rsp_valid && discard_q != '0;
  // pend_q counts allocated-but-unfilled entries, i.e. what a flush must discard
  assign fill_now = imem_rsp_valid && discard_q == '0 && pend_q != '0;
  always_comb begin
    pc_mem_d = pc_mem_q;
    inst_mem_d = inst_mem_q;
    filled_d = filled_q;
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    count_d = count_q;
    pend_d = pend_q;
    discard_d = discard_q - (AW+1)'(drop);
    if (flush) begin
      discard_d = discard_q + pend_q - (AW+1)'(drop || fill_now);
      head_d = tail_q;
      fill_d = tail_q;
      count_d = '0;
      pend_d = '0;
    end else begin
      if (fill_now) begin
        inst_mem_d[fill_q] = imem_rsp_data;
        filled_d[fill_q] = 1'b1;
        fill_d = fill_q + 1'b1;
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d = head_q + 1'b1;
      end
      if (accept) begin
        pc_mem_d[tail_q] = pc;
        filled_d[tail_q] = 1'b0;
        tail_d = tail_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(accept) - (AW+1)'(pop);
      pend_d = pend_q + (AW+1)'(accept) - (AW+1)'(fill_now);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i] <= '0;
        inst_mem_q[i] <= '0;
      end
      filled_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      count_q <= '0;
      pend_q <= '0;
      discard_q <= '0;
    end else begin
      pc_mem_q <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      filled_q <= filled_d;
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      count_q <= count_d;
      pend_q <= pend_d;
      discard_q <= discard_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, drop_cnt_q, drop_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(pc_stall && stall_cnt_q != '1);
    drop_cnt_d = drop_cnt_q + 32'(drop && drop_cnt_q != '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_drop_cnt = drop_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus random traffic against a queue-based fetch buffer model.
module tb_inst_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] SENT = 32'hFFFF_FFFC;
  logic clk = 0, rst, flush, imem_req_ready, imem_rsp_valid, out_ready;
  logic [31:0] pc, imem_rsp_data;
  logic pc_stall, imem_req_valid, out_valid;
  logic [31:0] imem_req_addr, out_pc, out_inst, perf_stall_cnt, perf_drop_cnt;
  inst_fetch_unit #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_stall(pc_stall), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .perf_stall_cnt(perf_stall_cnt), .perf_drop_cnt(perf_drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic [31:0] inst; bit f;} ent_t;
  ent_t q[$];
  int mcyc[$];
  int disc, cyc, checks, errors;
  logic [31:0] seq, m_stall, m_drop;
  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1; pc = SENT; flush = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q.delete(); mcyc.delete();
    disc = 0; seq = 0; m_stall = 0; m_drop = 0;
  endtask
  task automatic step(logic [31:0] p, bit fl, bit rdy, bit rsp, bit ordy);
    bit er, es, ev, rv, done;
    int unf;
    ent_t e;
    pc = p; flush = fl; imem_req_ready = rdy; out_ready = ordy;
    rv = rsp && mcyc.size() > 0 && mcyc[0] < cyc;
    imem_rsp_valid = rv;
    imem_rsp_data = rv ? 32'h00500093 ^ (seq * 32'h9E3779B1) : '0;
    er = !fl && p != SENT && (q.size() + disc) < DEPTH;
    es = p != SENT && !fl && !(er && rdy);
    ev = q.size() > 0 && q[0].f && !fl;
    #1;
    check("req_valid", imem_req_valid, er);
    check("pc_stall", pc_stall, es);
    check("out_valid", out_valid, ev);
    if (er) check("req_addr", imem_req_addr, p);
    if (ev) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_inst", out_inst, q[0].inst);
    end
`ifdef FETCH_PERF_EN
    check("perf_stall", perf_stall_cnt, m_stall);
    check("perf_drop", perf_drop_cnt, m_drop);
`else
    check("perf_tied", {perf_stall_cnt, perf_drop_cnt}, 64'd0);
`endif
    @(posedge clk);
    unf = 0;
    foreach (q[i]) if (!q[i].f) unf++;
    if (es) m_stall++;
    if (rv && disc > 0) m_drop++;
    if (fl) begin
      if (rv) begin
        if (disc > 0) disc--;
        else if (unf > 0) unf--;
      end
      disc += unf;
      q.delete();
    end else begin
      if (rv) begin
        if (disc > 0) disc--;
        else begin
          done = 0;
          for (int i = 0; i < q.size(); i++)
            if (!done && !q[i].f) begin q[i].f = 1; q[i].inst = imem_rsp_data; done = 1; end
        end
      end
      if (ev && ordy) void'(q.pop_front());
      if (er && rdy) begin e.pc = p; e.inst = '0; e.f = 0; q.push_back(e); end
    end
    if (rv) begin void'(mcyc.pop_front()); seq++; end
    if (er && rdy) mcyc.push_back(cyc);
    cyc++;
    #1;
  endtask
  task automatic drain();
    repeat (8) step(SENT, 0, 1, 1, 1);
  endtask
  initial begin
    checks = 0; errors = 0; cyc = 0;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_pc_stall", pc_stall, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_inst", out_inst, 0);
    step(SENT, 0, 1, 0, 0);
    step(32'h0, 0, 1, 0, 0);
    step(SENT, 0, 1, 0, 0);
    step(SENT, 0, 1, 1, 0);
    check("single_valid", out_valid, 1);
    check("single_pc", out_pc, 32'h0);
    check("single_inst", out_inst, 32'h00500093);
    step(SENT, 0, 1, 0, 1);
    check("single_popped", out_valid, 0);
    for (int i = 0; i < 4; i++) step(32'(i * 4), 0, 1, 1, 0);
    repeat (3) step(32'h10, 0, 1, 1, 0);
    check("full_stall", pc_stall, 1);
    check("full_noreq", imem_req_valid, 0);
    step(32'h10, 0, 1, 0, 1);
    check("full_freed_req", imem_req_valid, 1);
    step(32'h10, 0, 1, 0, 0);
    drain();
    repeat (3) step(32'h20, 0, 0, 0, 0);
    check("bp_stall", pc_stall, 1);
    check("bp_addr", imem_req_addr, 32'h20);
    step(32'h20, 0, 1, 0, 0);
    drain();
    step(32'h40, 0, 1, 0, 0);
    step(32'h44, 0, 1, 1, 0);
    step(32'h48, 0, 1, 0, 0);
    check("pre_flush_valid", out_valid, 1);
    step(32'h100, 1, 1, 0, 0);
    check("flush_valid", out_valid, 0);
    check("flush_stall", pc_stall, 0);
    step(32'h100, 0, 1, 0, 0);
    repeat (3) step(SENT, 0, 1, 1, 0);
    check("redirect_valid", out_valid, 1);
    check("redirect_pc", out_pc, 32'h100);
`ifdef FETCH_PERF_EN
    check("drop_two", perf_drop_cnt, 32'd2);
`endif
    drain();
    step(32'h200, 0, 1, 0, 0);
    step(32'h204, 0, 1, 0, 0);
    step(32'h300, 1, 1, 1, 0);
    step(32'h300, 0, 1, 0, 0);
    repeat (2) step(SENT, 0, 1, 1, 0);
    check("coinc_pc", out_pc, 32'h300);
    drain();
    for (int n = 0; n < 3000; n++)
      step($urandom_range(7) == 0 ? SENT : 32'($urandom_range(255)) << 2,
           $urandom_range(15) == 0, $urandom_range(3) != 0,
           $urandom_range(1) == 1, $urandom_range(1) == 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
